// File: rtl/avr_cpu_pkg.sv
// Shared AVR CPU definitions: operation codes, opcode mask/match pairs and
// the two-word instruction predicate.
package avr_cpu_pkg;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_EOR, OP_MOV, OP_CP, OP_CPC,
    OP_LDI, OP_SUBI, OP_SBCI, OP_ANDI, OP_ORI, OP_CPI,
    OP_INC, OP_DEC, OP_COM, OP_NEG, OP_LSR, OP_ROR, OP_ASR, OP_SWAP,
    OP_RJMP, OP_RCALL, OP_BRBS, OP_BRBC, OP_RET,
    OP_JMP, OP_CALL, OP_LDS, OP_STS
  } avr_op_t;

  // Operand layout selector used by the field extractor.
  typedef enum logic [2:0] {
    FMT_NONE, FMT_RR, FMT_IMM8, FMT_RD, FMT_REL12, FMT_BR, FMT_JMP, FMT_LDS
  } avr_fmt_t;

  localparam logic [15:0] M_ALU  = 16'hFC00;
  localparam logic [15:0] M_IMM  = 16'hF000;
  localparam logic [15:0] M_ONE  = 16'hFE0F;
  localparam logic [15:0] M_JMP  = 16'hFE0E;
  localparam logic [15:0] M_BR   = 16'hFC00;
  localparam logic [15:0] M_FULL = 16'hFFFF;

  localparam logic [15:0] X_ADD  = 16'h0C00, X_ADC  = 16'h1C00, X_SUB  = 16'h1800;
  localparam logic [15:0] X_SBC  = 16'h0800, X_AND  = 16'h2000, X_EOR  = 16'h2400;
  localparam logic [15:0] X_OR   = 16'h2800, X_MOV  = 16'h2C00, X_CP   = 16'h1400;
  localparam logic [15:0] X_CPC  = 16'h0400;
  localparam logic [15:0] X_LDI  = 16'hE000, X_CPI  = 16'h3000, X_SBCI = 16'h4000;
  localparam logic [15:0] X_SUBI = 16'h5000, X_ORI  = 16'h6000, X_ANDI = 16'h7000;
  localparam logic [15:0] X_COM  = 16'h9400, X_NEG  = 16'h9401, X_SWAP = 16'h9402;
  localparam logic [15:0] X_INC  = 16'h9403, X_ASR  = 16'h9405, X_LSR  = 16'h9406;
  localparam logic [15:0] X_ROR  = 16'h9407, X_DEC  = 16'h940A;
  localparam logic [15:0] X_RJMP = 16'hC000, X_RCALL = 16'hD000;
  localparam logic [15:0] X_BRBS = 16'hF000, X_BRBC = 16'hF400;
  localparam logic [15:0] X_RET  = 16'h9508, X_NOP  = 16'h0000;
  localparam logic [15:0] X_JMP  = 16'h940C, X_CALL = 16'h940E;
  localparam logic [15:0] X_LDS  = 16'h9000, X_STS  = 16'h9200;

  function automatic logic op_match(input logic [15:0] w, input logic [15:0] mask,
                                    input logic [15:0] match);
    return (w & mask) == match;
  endfunction

  function automatic logic is_two_word(input logic [15:0] w);
    return op_match(w, M_JMP, X_JMP) || op_match(w, M_JMP, X_CALL) ||
           op_match(w, M_ONE, X_LDS) || op_match(w, M_ONE, X_STS);
  endfunction

endpackage

// File: rtl/avr_cpu_decode_comb.sv
// Combinational classification and operand extraction for one 16-bit word.
// Two-word first words yield their partial fields; the top merges word two.
module avr_cpu_decode_comb
  import avr_cpu_pkg::*;
(
  input  logic [15:0] i_word,
  output avr_op_t     o_op,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rr,
  output logic [21:0] o_imm,
  output logic        o_illegal,
  output logic        o_two_word
);

  avr_op_t  w_op;
  avr_fmt_t w_fmt;
  logic     w_illegal;

  always_comb begin
    w_op      = OP_NOP;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    if      (op_match(i_word, M_FULL, X_NOP))   begin w_op = OP_NOP;   w_fmt = FMT_NONE;  end
    else if (op_match(i_word, M_ALU, X_ADD))    begin w_op = OP_ADD;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_ADC))    begin w_op = OP_ADC;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_SUB))    begin w_op = OP_SUB;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_SBC))    begin w_op = OP_SBC;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_AND))    begin w_op = OP_AND;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_OR))     begin w_op = OP_OR;    w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_EOR))    begin w_op = OP_EOR;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_MOV))    begin w_op = OP_MOV;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_CP))     begin w_op = OP_CP;    w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_ALU, X_CPC))    begin w_op = OP_CPC;   w_fmt = FMT_RR;    end
    else if (op_match(i_word, M_IMM, X_LDI))    begin w_op = OP_LDI;   w_fmt = FMT_IMM8;  end
    else if (op_match(i_word, M_IMM, X_SUBI))   begin w_op = OP_SUBI;  w_fmt = FMT_IMM8;  end
    else if (op_match(i_word, M_IMM, X_SBCI))   begin w_op = OP_SBCI;  w_fmt = FMT_IMM8;  end
    else if (op_match(i_word, M_IMM, X_ANDI))   begin w_op = OP_ANDI;  w_fmt = FMT_IMM8;  end
    else if (op_match(i_word, M_IMM, X_ORI))    begin w_op = OP_ORI;   w_fmt = FMT_IMM8;  end
    else if (op_match(i_word, M_IMM, X_CPI))    begin w_op = OP_CPI;   w_fmt = FMT_IMM8;  end
    else if (op_match(i_word, M_ONE, X_INC))    begin w_op = OP_INC;   w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_ONE, X_DEC))    begin w_op = OP_DEC;   w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_ONE, X_COM))    begin w_op = OP_COM;   w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_ONE, X_NEG))    begin w_op = OP_NEG;   w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_ONE, X_LSR))    begin w_op = OP_LSR;   w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_ONE, X_ROR))    begin w_op = OP_ROR;   w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_ONE, X_ASR))    begin w_op = OP_ASR;   w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_ONE, X_SWAP))   begin w_op = OP_SWAP;  w_fmt = FMT_RD;    end
    else if (op_match(i_word, M_IMM, X_RJMP))   begin w_op = OP_RJMP;  w_fmt = FMT_REL12; end
    else if (op_match(i_word, M_IMM, X_RCALL))  begin w_op = OP_RCALL; w_fmt = FMT_REL12; end
    else if (op_match(i_word, M_BR, X_BRBS))    begin w_op = OP_BRBS;  w_fmt = FMT_BR;    end
    else if (op_match(i_word, M_BR, X_BRBC))    begin w_op = OP_BRBC;  w_fmt = FMT_BR;    end
    else if (op_match(i_word, M_FULL, X_RET))   begin w_op = OP_RET;   w_fmt = FMT_NONE;  end
    else if (op_match(i_word, M_JMP, X_JMP))    begin w_op = OP_JMP;   w_fmt = FMT_JMP;   end
    else if (op_match(i_word, M_JMP, X_CALL))   begin w_op = OP_CALL;  w_fmt = FMT_JMP;   end
    else if (op_match(i_word, M_ONE, X_LDS))    begin w_op = OP_LDS;   w_fmt = FMT_LDS;   end
    else if (op_match(i_word, M_ONE, X_STS))    begin w_op = OP_STS;   w_fmt = FMT_LDS;   end
    else w_illegal = 1'b1;
  end

  always_comb begin
    o_rd  = '0;
    o_rr  = '0;
    o_imm = '0;
    case (w_fmt)
      FMT_RR:    begin o_rd = i_word[8:4]; o_rr = {i_word[9], i_word[3:0]}; end
      FMT_IMM8:  begin
        o_rd  = {1'b1, i_word[7:4]};
        o_imm = {14'd0, i_word[11:8], i_word[3:0]};
      end
      FMT_RD:    o_rd = i_word[8:4];
      FMT_REL12: o_imm = {{10{i_word[11]}}, i_word[11:0]};
      FMT_BR:    begin o_imm = {{15{i_word[9]}}, i_word[9:3]}; o_rr = {2'b00, i_word[2:0]}; end
      // Upper address bits sit in place; word two is ORed into [15:0].
      FMT_JMP:   o_imm = {i_word[8:4], i_word[0], 16'h0000};
      FMT_LDS:   o_rd = i_word[8:4];
      default:   ;
    endcase
  end

  assign o_op       = w_op;
  assign o_illegal  = w_illegal;
  assign o_two_word = is_two_word(i_word);

endmodule

// File: rtl/avr_cpu_decode.sv
// AVR decode stage: registers one decoded instruction per accepted word and
// reassembles JMP/CALL/LDS/STS across two words.
module avr_cpu_decode
  import avr_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] opcode,
  input  logic        opcode_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        dec_valid,
  output avr_op_t     dec_op,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rr,
  output logic [21:0] dec_imm,
  output logic        dec_illegal
);

  typedef enum logic {ST_IDLE, ST_WORD2} state_t;

  state_t      r_state, w_state_n;
  logic        r_valid, w_valid_n;
  avr_op_t     r_op, w_op_n;
  logic [4:0]  r_rd, w_rd_n, r_rr, w_rr_n;
  logic [21:0] r_imm, w_imm_n;
  logic        r_ill, w_ill_n;
  avr_op_t     r_pend_op, w_pend_op_n;
  logic [4:0]  r_pend_rd, w_pend_rd_n;
  logic [21:0] r_pend_imm, w_pend_imm_n;

  avr_op_t     w_op;
  logic [4:0]  w_rd, w_rr;
  logic [21:0] w_imm;
  logic        w_ill, w_two;

  avr_cpu_decode_comb u_comb (
    .i_word     (opcode),
    .o_op       (w_op),
    .o_rd       (w_rd),
    .o_rr       (w_rr),
    .o_imm      (w_imm),
    .o_illegal  (w_ill),
    .o_two_word (w_two)
  );

  always_comb begin
    w_state_n    = r_state;
    w_valid_n    = r_valid;
    w_op_n       = r_op;
    w_rd_n       = r_rd;
    w_rr_n       = r_rr;
    w_imm_n      = r_imm;
    w_ill_n      = r_ill;
    w_pend_op_n  = r_pend_op;
    w_pend_rd_n  = r_pend_rd;
    w_pend_imm_n = r_pend_imm;
    if (flush) begin
      w_state_n = ST_IDLE;
      w_valid_n = 1'b0;
    end else if (!stall) begin
      if (!opcode_valid) begin
        w_valid_n = 1'b0;
      end else if (r_state == ST_WORD2) begin
        // This word is pure operand data; it never goes through classification.
        w_state_n = ST_IDLE;
        w_valid_n = 1'b1;
        w_op_n    = r_pend_op;
        w_rd_n    = r_pend_rd;
        w_rr_n    = '0;
        w_imm_n   = r_pend_imm | {6'd0, opcode};
        w_ill_n   = 1'b0;
      end else if (w_two) begin
        w_state_n    = ST_WORD2;
        w_valid_n    = 1'b0;
        w_pend_op_n  = w_op;
        w_pend_rd_n  = w_rd;
        w_pend_imm_n = w_imm;
      end else begin
        w_valid_n = 1'b1;
        w_op_n    = w_op;
        w_rd_n    = w_rd;
        w_rr_n    = w_rr;
        w_imm_n   = w_imm;
        w_ill_n   = w_ill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_valid    <= 1'b0;
      r_op       <= OP_NOP;
      r_rd       <= '0;
      r_rr       <= '0;
      r_imm      <= '0;
      r_ill      <= 1'b0;
      r_pend_op  <= OP_NOP;
      r_pend_rd  <= '0;
      r_pend_imm <= '0;
    end else begin
      r_state    <= w_state_n;
      r_valid    <= w_valid_n;
      r_op       <= w_op_n;
      r_rd       <= w_rd_n;
      r_rr       <= w_rr_n;
      r_imm      <= w_imm_n;
      r_ill      <= w_ill_n;
      r_pend_op  <= w_pend_op_n;
      r_pend_rd  <= w_pend_rd_n;
      r_pend_imm <= w_pend_imm_n;
    end
  end

  assign dec_valid   = r_valid;
  assign dec_op      = r_op;
  assign dec_rd      = r_rd;
  assign dec_rr      = r_rr;
  assign dec_imm     = r_imm;
  assign dec_illegal = r_ill;

endmodule

// File: tb/tb_avr_cpu_decode.sv
// Self-checking bench for avr_cpu_decode: directed test-plan steps followed by
// randomized traffic against an instruction-level reference model.
module tb_avr_cpu_decode;
  import avr_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] opcode = '0;
  logic        opcode_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        dec_valid, dec_illegal;
  avr_op_t     dec_op;
  logic [4:0]  dec_rd, dec_rr;
  logic [21:0] dec_imm;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [21:0] imm;
    logic        ill;
    logic        two;
  } dec_t;

  dec_t        e;
  logic        e_valid = 1'b0;
  logic        e_fchk  = 1'b0;
  logic        m_w2    = 1'b0;
  logic [15:0] m_first = '0;

  avr_cpu_decode dut (
    .clk(clk), .rst(rst), .opcode(opcode), .opcode_valid(opcode_valid),
    .stall(stall), .flush(flush), .dec_valid(dec_valid), .dec_op(dec_op),
    .dec_rd(dec_rd), .dec_rr(dec_rr), .dec_imm(dec_imm), .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] sext(input int v);
    return v[21:0];
  endfunction

  // Instruction-set view of one word, written from the AVR encoding table.
  function automatic dec_t ref_decode(input logic [15:0] w);
    dec_t   d = '0;
    logic [5:0] k;
    int     off;
    casez (w)
      16'b0000_0000_0000_0000: k = OP_NOP;
      16'b0000_11??_????_????: k = OP_ADD;
      16'b0001_11??_????_????: k = OP_ADC;
      16'b0001_10??_????_????: k = OP_SUB;
      16'b0000_10??_????_????: k = OP_SBC;
      16'b0010_00??_????_????: k = OP_AND;
      16'b0010_10??_????_????: k = OP_OR;
      16'b0010_01??_????_????: k = OP_EOR;
      16'b0010_11??_????_????: k = OP_MOV;
      16'b0001_01??_????_????: k = OP_CP;
      16'b0000_01??_????_????: k = OP_CPC;
      16'b1110_????_????_????: k = OP_LDI;
      16'b0101_????_????_????: k = OP_SUBI;
      16'b0100_????_????_????: k = OP_SBCI;
      16'b0111_????_????_????: k = OP_ANDI;
      16'b0110_????_????_????: k = OP_ORI;
      16'b0011_????_????_????: k = OP_CPI;
      16'b1001_010?_????_0011: k = OP_INC;
      16'b1001_010?_????_1010: k = OP_DEC;
      16'b1001_010?_????_0000: k = OP_COM;
      16'b1001_010?_????_0001: k = OP_NEG;
      16'b1001_010?_????_0110: k = OP_LSR;
      16'b1001_010?_????_0111: k = OP_ROR;
      16'b1001_010?_????_0101: k = OP_ASR;
      16'b1001_010?_????_0010: k = OP_SWAP;
      16'b1100_????_????_????: k = OP_RJMP;
      16'b1101_????_????_????: k = OP_RCALL;
      16'b1111_00??_????_????: k = OP_BRBS;
      16'b1111_01??_????_????: k = OP_BRBC;
      16'b1001_0101_0000_1000: k = OP_RET;
      16'b1001_010?_????_110?: k = OP_JMP;
      16'b1001_010?_????_111?: k = OP_CALL;
      16'b1001_000?_????_0000: k = OP_LDS;
      16'b1001_001?_????_0000: k = OP_STS;
      default: begin k = OP_NOP; d.ill = 1'b1; end
    endcase
    d.op = k;
    if (k inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_EOR, OP_MOV, OP_CP, OP_CPC}) begin
      d.rd = w[8:4];
      d.rr = {w[9], w[3:0]};
    end else if (k inside {OP_LDI, OP_SUBI, OP_SBCI, OP_ANDI, OP_ORI, OP_CPI}) begin
      d.rd  = 5'(16 + int'(w[7:4]));
      d.imm = 22'(int'(w[11:8]) * 16 + int'(w[3:0]));
    end else if (k inside {OP_INC, OP_DEC, OP_COM, OP_NEG, OP_LSR, OP_ROR, OP_ASR, OP_SWAP,
                           OP_LDS, OP_STS}) begin
      d.rd = w[8:4];
    end else if (k inside {OP_RJMP, OP_RCALL}) begin
      off   = w[11] ? int'(w[11:0]) - 4096 : int'(w[11:0]);
      d.imm = sext(off);
    end else if (k inside {OP_BRBS, OP_BRBC}) begin
      off   = w[9] ? int'(w[9:3]) - 128 : int'(w[9:3]);
      d.imm = sext(off);
      d.rr  = 5'(int'(w[2:0]));
    end
    d.two = (k == OP_JMP) || (k == OP_CALL) || (k == OP_LDS) || (k == OP_STS);
    return d;
  endfunction

  function automatic dec_t ref_complete(input logic [15:0] first, input logic [15:0] second);
    dec_t d = ref_decode(first);
    if (d.op == OP_JMP || d.op == OP_CALL)
      d.imm = 22'(int'(first[8:4]) * 131072 + int'(first[0]) * 65536 + int'(second));
    else
      d.imm = 22'(int'(second));
    d.two = 1'b0;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic [15:0] w, input logic v, input logic s,
                              input logic f, input logic r);
    dec_t d;
    if (r) begin
      m_w2 = 1'b0; e = '0; e.op = OP_NOP; e_valid = 1'b0; e_fchk = 1'b1;
    end else if (f) begin
      m_w2 = 1'b0; e_valid = 1'b0; e_fchk = 1'b0;
    end else if (s) begin
      // everything held
    end else if (!v) begin
      e_valid = 1'b0; e_fchk = 1'b0;
    end else if (m_w2) begin
      e = ref_complete(m_first, w); e_valid = 1'b1; e_fchk = 1'b1; m_w2 = 1'b0;
    end else begin
      d = ref_decode(w);
      if (d.two) begin
        m_first = w; m_w2 = 1'b1; e_valid = 1'b0; e_fchk = 1'b0;
      end else begin
        e = d; e_valid = 1'b1; e_fchk = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [15:0] w, input logic v, input logic s,
                      input logic f, input logic r);
    opcode = w; opcode_valid = v; stall = s; flush = f; rst = r;
    @(posedge clk);
    #1;
    model_update(w, v, s, f, r);
    chk("valid", dec_valid, e_valid);
    if (e_fchk) begin
      chk("op",  dec_op,      e.op);
      chk("rd",  dec_rd,      e.rd);
      chk("rr",  dec_rr,      e.rr);
      chk("imm", dec_imm,     e.imm);
      chk("ill", dec_illegal, e.ill);
    end
  endtask

  task automatic run(input logic [15:0] w);
    step(w, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  logic [15:0] pool [16] = '{16'h0C12, 16'hEA45, 16'h940D, 16'h95FF, 16'h91F0, 16'h9200,
                             16'hCFFE, 16'hD123, 16'hF7F9, 16'hF00A, 16'h9513, 16'h9508,
                             16'h0000, 16'hFFFF, 16'h940A, 16'h2D3F};

  initial begin
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", dec_valid, 0);
    chk("rst_op", dec_op, OP_NOP);
    chk("rst_imm", dec_imm, 0);
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    run(16'h0C12);
    chk("add_op", dec_op, OP_ADD); chk("add_rd", dec_rd, 1); chk("add_rr", dec_rr, 2);
    run(16'hEA45);
    chk("ldi_op", dec_op, OP_LDI); chk("ldi_rd", dec_rd, 20); chk("ldi_imm", dec_imm, 32'h0A5);

    run(16'h940D);
    chk("jmp_bubble", dec_valid, 0);
    run(16'h2345);
    chk("jmp_op", dec_op, OP_JMP); chk("jmp_imm", dec_imm, 32'h12345);

    run(16'hCFFE);
    chk("rjmp_imm", dec_imm, 32'h3FFFFE);
    for (int i = 0; i < 3; i++) begin
      step(16'h0C12, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stall_op", dec_op, OP_RJMP); chk("stall_imm", dec_imm, 32'h3FFFFE);
    end
    run(16'h0C12);
    chk("post_stall_op", dec_op, OP_ADD);

    run(16'h9100);
    step(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", dec_valid, 0);
    run(16'h0C12);
    chk("post_flush_op", dec_op, OP_ADD); chk("post_flush_rr", dec_rr, 2);

    run(16'hFFFF);
    chk("ill_flag", dec_illegal, 1); chk("ill_op", dec_op, OP_NOP); chk("ill_rd", dec_rd, 0);

    run(16'h940C);
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("w2rst_valid", dec_valid, 0); chk("w2rst_op", dec_op, OP_NOP); chk("w2rst_ill", dec_illegal, 0);
    run(16'h2345);
    chk("w2rst_and", dec_op, OP_AND);

    run(16'h95FF); chk("b2b_bub1", dec_valid, 0);
    run(16'h1234); chk("call_op", dec_op, OP_CALL); chk("call_imm", dec_imm, 32'h3F1234);
    run(16'h91F0); chk("b2b_bub2", dec_valid, 0);
    run(16'hBEEF); chk("lds_rd", dec_rd, 31); chk("lds_imm", dec_imm, 32'h0BEEF);

    run(16'hF7F9); chk("brbc_imm", dec_imm, 32'h3FFFFF); chk("brbc_rr", dec_rr, 1);
    run(16'h9513); chk("inc_rd", dec_rd, 17);

    run(16'h940C);
    step(16'h1111, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_stall", dec_valid, 0);
    run(16'h0C12); chk("flush_stall_add", dec_op, OP_ADD);
    step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_invalid_hold", dec_valid, 1);
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("invalid_drop", dec_valid, 0);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] w;
      w = ($urandom_range(0, 99) < 45) ? pool[$urandom_range(0, 15)] : 16'($urandom);
      step(w, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
